// File: rtl/pcie_mwr_tx.sv
// Posted MWr32 TLP builder for the 16-bit VC0 tx port: credit check, tx_req handshake,
// 6 header beats, then payload beats streamed live from a first-word-fall-through source.
module pcie_mwr_tx #(
  parameter int MAX_LEN_DW = 32,
  parameter int LEN_W      = 6
) (
  input  logic             pcie_clk,
  input  logic             sys_rst,
  input  logic [7:0]       bus_num,
  input  logic [4:0]       dev_num,
  input  logic [2:0]       func_num,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [29:0]      req_addr,
  input  logic [LEN_W-1:0] req_len_dw,
  output logic             req_err,
  input  logic [31:0]      dat_data,
  output logic             dat_rd,
  output logic             tx_req,
  input  logic             tx_rdy,
  output logic             tx_st,
  output logic             tx_end,
  output logic [15:0]      tx_data,
  input  logic [8:0]       tx_ca_ph,
  input  logic [12:0]      tx_ca_pd,
  input  logic             tx_ca_p_recheck,
  output logic             busy
);

  localparam int LW1 = LEN_W + 1;
  localparam logic [LEN_W:0] MAX_LEN = LW1'(MAX_LEN_DW);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, HDR, DATA} state_t;

  state_t           state, state_n;
  logic [2:0]       hdr_idx, hdr_idx_n;
  logic             lo_half, lo_half_n;
  logic [LEN_W-1:0] dw_left, dw_left_n;
  logic             tx_req_n, tx_st_n, tx_end_n, req_err_n;
  logic [15:0]      tx_data_r, tx_data_r_n;

  logic [29:0]      addr_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W:0]   pd_need;
  logic             len_bad, credit_ok, accept;
  logic [95:0]      hdr;

  function automatic logic [15:0] hdr_beat(input logic [95:0] h, input logic [2:0] i);
    logic [15:0] b;
    case (i)
      3'd0:    b = h[95:80];
      3'd1:    b = h[79:64];
      3'd2:    b = h[63:48];
      3'd3:    b = h[47:32];
      3'd4:    b = h[31:16];
      default: b = h[15:0];
    endcase
    return b;
  endfunction

  assign req_ready = (state == IDLE) & ~sys_rst;
  assign accept    = req_valid & req_ready;
  assign len_bad   = (req_len_dw == '0) | ({1'b0, req_len_dw} > MAX_LEN);
  assign busy      = (state != IDLE);

  // Data credits are in 4-DW units, so the requirement is ceil(len/4).
  assign pd_need   = ({1'b0, len_r} + LW1'(3)) >> 2;
  assign credit_ok = (tx_ca_ph[8] | (tx_ca_ph[7:0] != 8'd0)) &
                     (tx_ca_pd[12] | (tx_ca_pd[11:0] >= 12'(pd_need)));

  assign hdr = {1'b0, 2'b10, 5'b00000, 1'b0, 3'b000, 4'b0000,
                1'b0, 1'b0, 2'b00, 2'b00, 10'(len_r),
                bus_num, dev_num, func_num, 8'h00,
                ((len_r == LEN_W'(1)) ? 4'h0 : 4'hF), 4'hF,
                addr_r, 2'b00};

  // Payload halves come straight from the FWFT word, which only advances on dat_rd,
  // so a tx_rdy stall naturally freezes the beat.
  assign tx_data = (state == DATA) ? (lo_half ? dat_data[15:0] : dat_data[31:16]) : tx_data_r;
  assign dat_rd  = (state == DATA) & lo_half & tx_rdy & ~sys_rst;

  always_ff @(posedge pcie_clk) begin
    if (accept) begin
      addr_r <= req_addr;
      len_r  <= req_len_dw;
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      hdr_idx   <= '0;
      lo_half   <= 1'b0;
      dw_left   <= '0;
      tx_req    <= 1'b0;
      tx_st     <= 1'b0;
      tx_end    <= 1'b0;
      tx_data_r <= '0;
      req_err   <= 1'b0;
    end else begin
      state     <= state_n;
      hdr_idx   <= hdr_idx_n;
      lo_half   <= lo_half_n;
      dw_left   <= dw_left_n;
      tx_req    <= tx_req_n;
      tx_st     <= tx_st_n;
      tx_end    <= tx_end_n;
      tx_data_r <= tx_data_r_n;
      req_err   <= req_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    hdr_idx_n   = hdr_idx;
    lo_half_n   = lo_half;
    dw_left_n   = dw_left;
    tx_req_n    = tx_req;
    tx_st_n     = tx_st;
    tx_end_n    = tx_end;
    tx_data_r_n = tx_data_r;
    req_err_n   = 1'b0;
    case (state)
      IDLE: begin
        tx_req_n    = 1'b0;
        tx_st_n     = 1'b0;
        tx_end_n    = 1'b0;
        tx_data_r_n = '0;
        if (accept) begin
          if (len_bad) req_err_n = 1'b1;
          else         state_n   = CHECK;
        end
      end
      CHECK: begin
        if (credit_ok) begin
          state_n  = REQ;
          tx_req_n = 1'b1;
        end
      end
      REQ: begin
        if (tx_rdy) begin
          state_n     = HDR;
          tx_req_n    = 1'b0;
          tx_st_n     = 1'b1;
          hdr_idx_n   = 3'd0;
          tx_data_r_n = hdr_beat(hdr, 3'd0);
        end else if (tx_ca_p_recheck) begin
          state_n  = CHECK;
          tx_req_n = 1'b0;
        end
      end
      HDR: begin
        if (tx_rdy) begin
          tx_st_n = 1'b0;
          if (hdr_idx == 3'd5) begin
            state_n     = DATA;
            lo_half_n   = 1'b0;
            dw_left_n   = len_r;
            tx_data_r_n = '0;
          end else begin
            hdr_idx_n   = hdr_idx + 3'd1;
            tx_data_r_n = hdr_beat(hdr, hdr_idx + 3'd1);
          end
        end
      end
      DATA: begin
        if (tx_rdy) begin
          if (!lo_half) begin
            lo_half_n = 1'b1;
            tx_end_n  = (dw_left == LEN_W'(1));
          end else if (dw_left == LEN_W'(1)) begin
            state_n  = IDLE;
            tx_end_n = 1'b0;
          end else begin
            lo_half_n = 1'b0;
            dw_left_n = dw_left - LEN_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pcie_mwr_tx.sv
// Directed bench for pcie_mwr_tx: table of TLP requests with hand-computed header beats,
// plus sequences for length errors, credit stall, recheck and reset mid-TLP.
module tb_pcie_mwr_tx;
  localparam int MAX_LEN_DW = 32;
  localparam int LEN_W      = 6;

  logic             pcie_clk = 1'b0;
  logic             sys_rst  = 1'b1;
  logic [7:0]       bus_num  = '0;
  logic [4:0]       dev_num  = '0;
  logic [2:0]       func_num = '0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [29:0]      req_addr = '0;
  logic [LEN_W-1:0] req_len_dw = '0;
  logic             req_err;
  logic [31:0]      dat_data;
  logic             dat_rd;
  logic             tx_req;
  logic             tx_rdy = 1'b0;
  logic             tx_st, tx_end;
  logic [15:0]      tx_data;
  logic [8:0]       tx_ca_ph = 9'h010;
  logic [12:0]      tx_ca_pd = 13'h0100;
  logic             tx_ca_p_recheck = 1'b0;
  logic             busy;

  pcie_mwr_tx #(.MAX_LEN_DW(MAX_LEN_DW), .LEN_W(LEN_W)) dut (
    .pcie_clk(pcie_clk), .sys_rst(sys_rst), .bus_num(bus_num), .dev_num(dev_num),
    .func_num(func_num), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len_dw(req_len_dw), .req_err(req_err), .dat_data(dat_data), .dat_rd(dat_rd),
    .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_st(tx_st), .tx_end(tx_end), .tx_data(tx_data),
    .tx_ca_ph(tx_ca_ph), .tx_ca_pd(tx_ca_pd), .tx_ca_p_recheck(tx_ca_p_recheck), .busy(busy)
  );

  always #4 pcie_clk = ~pcie_clk;

  typedef struct {
    logic [LEN_W-1:0]  len;
    logic [29:0]       addr;
    logic [7:0]        bus;
    logic [4:0]        dev;
    logic [2:0]        func;
    logic [0:5][15:0]  hdr;
    int                stall_at;
    int                stall_n;
  } row_t;

  row_t        rows [6];
  logic [31:0] src [0:127];
  logic [6:0]  src_idx = '0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          exp_base = 0;

  // FWFT payload source: next word appears after each dat_rd.
  assign dat_data = src[src_idx];
  always @(posedge pcie_clk) if (dat_rd) src_idx <= src_idx + 7'd1;

  task automatic step();
    @(negedge pcie_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_beat(input int r, input int k);
    logic [31:0] dw;
    if (k < 6) return rows[r].hdr[k];
    dw = src[7'(exp_base + (k - 6) / 2)];
    return (((k - 6) % 2) == 0) ? dw[31:16] : dw[15:0];
  endfunction

  task automatic issue(input int r);
    bus_num  = rows[r].bus;
    dev_num  = rows[r].dev;
    func_num = rows[r].func;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_addr   = rows[r].addr;
    req_len_dw = rows[r].len;
    step();
    req_valid = 1'b0;
    chk("req_err_good_len", 32'(req_err), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Expects tx_req already high; grants and collects beats, applying the row's stall.
  task automatic send(input int r);
    int nacc = 0, stalled = 0, nrd = 0, total;
    bit done = 1'b0;
    logic rdy;
    total = 6 + 2 * int'(rows[r].len);
    chk("tx_req_before_grant", 32'(tx_req), 32'd1);
    tx_rdy = 1'b1;
    step();
    chk("tx_req_drops_with_st", 32'(tx_req), 32'd0);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      rdy = !(nacc == rows[r].stall_at && stalled < rows[r].stall_n);
      tx_rdy = rdy;
      #1;
      chk($sformatf("row%0d_beat%0d_data", r, nacc), 32'(tx_data), 32'(exp_beat(r, nacc)));
      if (rdy) begin
        chk($sformatf("row%0d_beat%0d_st", r, nacc), 32'(tx_st), 32'(nacc == 0));
        chk($sformatf("row%0d_beat%0d_end", r, nacc), 32'(tx_end), 32'(nacc == total - 1));
        chk($sformatf("row%0d_beat%0d_rd", r, nacc), 32'(dat_rd),
            32'(nacc >= 6 && ((nacc - 6) % 2) == 1));
        if (dat_rd) nrd++;
        if (tx_end) done = 1'b1;
        nacc++;
      end else begin
        stalled++;
        chk($sformatf("row%0d_stall_rd", r), 32'(dat_rd), 32'd0);
      end
      step();
    end
    tx_rdy = 1'b0;
    chk($sformatf("row%0d_end_seen", r), 32'(done), 32'd1);
    chk($sformatf("row%0d_beat_count", r), 32'(nacc), 32'(total));
    chk($sformatf("row%0d_dat_rd_count", r), 32'(nrd), 32'(rows[r].len));
    chk($sformatf("row%0d_idle_busy", r), 32'(busy), 32'd0);
    chk($sformatf("row%0d_idle_end", r), 32'(tx_end), 32'd0);
    chk($sformatf("row%0d_idle_data", r), 32'(tx_data), 32'd0);
    exp_base += int'(rows[r].len);
  endtask

  initial begin
    rows[0] = '{len: 6'd1, addr: 30'h0400_0000, bus: 8'h01, dev: 5'h00, func: 3'h0,
                hdr: {16'h4000, 16'h0001, 16'h0100, 16'h000F, 16'h1000, 16'h0000},
                stall_at: -1, stall_n: 0};
    rows[1] = '{len: 6'd4, addr: 30'h0000_0010, bus: 8'h01, dev: 5'h00, func: 3'h0,
                hdr: {16'h4000, 16'h0004, 16'h0100, 16'h00FF, 16'h0000, 16'h0040},
                stall_at: 2, stall_n: 1};
    rows[2] = '{len: 6'd32, addr: 30'h3FFF_FFFF, bus: 8'hAB, dev: 5'h1F, func: 3'h7,
                hdr: {16'h4000, 16'h0020, 16'hABFF, 16'h00FF, 16'hFFFF, 16'hFFFC},
                stall_at: 9, stall_n: 3};
    rows[3] = '{len: 6'd5, addr: 30'h0123_4567, bus: 8'h3C, dev: 5'h02, func: 3'h5,
                hdr: {16'h4000, 16'h0005, 16'h3C15, 16'h00FF, 16'h048D, 16'h159C},
                stall_at: 7, stall_n: 2};
    rows[4] = '{len: 6'd8, addr: 30'h0000_0100, bus: 8'h01, dev: 5'h00, func: 3'h0,
                hdr: {16'h4000, 16'h0008, 16'h0100, 16'h00FF, 16'h0000, 16'h0400},
                stall_at: -1, stall_n: 0};
    rows[5] = '{len: 6'd2, addr: 30'h0000_0020, bus: 8'h01, dev: 5'h00, func: 3'h0,
                hdr: {16'h4000, 16'h0002, 16'h0100, 16'h00FF, 16'h0000, 16'h0080},
                stall_at: -1, stall_n: 0};
    src[0] = 32'hDEADBEEF;
    for (int k = 1; k < 128; k++) src[k] = 32'hC0DE_0000 + 32'(k) * 32'h0001_0101;

    repeat (3) step();
    sys_rst = 1'b0;
    step();
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_tx_st", 32'(tx_st), 32'd0);
    chk("rst_tx_end", 32'(tx_end), 32'd0);
    chk("rst_dat_rd", 32'(dat_rd), 32'd0);
    chk("rst_req_err", 32'(req_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);

    for (int r = 0; r < 4; r++) begin
      issue(r);
      chk("tx_req_latency", 32'(tx_req), 32'd0);
      step();
      send(r);
    end

    for (int e = 0; e < 2; e++) begin
      req_valid  = 1'b1;
      req_len_dw = (e == 0) ? 6'd0 : 6'd33;
      step();
      req_valid = 1'b0;
      chk("len_err_pulse", 32'(req_err), 32'd1);
      chk("len_err_busy", 32'(busy), 32'd0);
      step();
      chk("len_err_one_cycle", 32'(req_err), 32'd0);
      chk("len_err_no_req", 32'(tx_req), 32'd0);
    end

    tx_ca_pd = 13'd1;
    issue(4);
    for (int i = 0; i < 4; i++) begin
      chk("credit_hold_req", 32'(tx_req), 32'd0);
      step();
    end
    tx_ca_pd = 13'd2;
    for (int i = 0; i < 2 && tx_req !== 1'b1; i++) step();
    send(4);
    tx_ca_pd = 13'h0100;

    issue(5);
    step();
    chk("recheck_req_up", 32'(tx_req), 32'd1);
    tx_ca_p_recheck = 1'b1;
    step();
    tx_ca_p_recheck = 1'b0;
    chk("recheck_req_drop", 32'(tx_req), 32'd0);
    chk("recheck_busy", 32'(busy), 32'd1);
    step();
    send(5);

    issue(3);
    step();
    chk("mid_rst_req", 32'(tx_req), 32'd1);
    tx_rdy = 1'b1;
    step();
    repeat (5) step();
    chk("mid_rst_beat5", 32'(tx_data), 32'h159C);
    sys_rst = 1'b1;
    tx_rdy  = 1'b0;
    step();
    chk("mid_rst_tx_req", 32'(tx_req), 32'd0);
    chk("mid_rst_tx_st", 32'(tx_st), 32'd0);
    chk("mid_rst_tx_end", 32'(tx_end), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_dat_rd", 32'(dat_rd), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    sys_rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    issue(3);
    step();
    send(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
